// File: rtl/wb_arb_pkg.sv
// Shared types and sizes for the writeback-select round-robin arbiter.
package wb_arb_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;

  typedef logic [NREQ-1:0]  req_vec_t;
  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/wb_sel_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first request at or after ptr wins.
module rr_pick
  import wb_arb_pkg::*;
(
  input  req_vec_t req,
  input  sel_t     ptr,
  input  logic     en,
  output req_vec_t gnt,
  output sel_t     idx,
  output logic     any_gnt
);

  sel_t cand;

  // Index arithmetic wraps naturally because NREQ is a power of two.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_gnt = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ptr + sel_t'(k);
      if (en && !any_gnt && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        any_gnt   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_sel_arbiter.sv
// Round-robin arbiter driving the registered writeback mux select.
// Optional owner lock enabled by defining WB_ARB_LOCK_EN.
module wb_sel_arbiter
  import wb_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  req_vec_t req,
  input  logic     stall,
`ifdef WB_ARB_LOCK_EN
  input  req_vec_t lock,
`endif
  output req_vec_t gnt,
  output sel_t     sel_q,
  output logic     sel_valid_q
);

  sel_t     ptr_q;
  sel_t     ptr_d;
  sel_t     sel_d;
  logic     valid_d;
  req_vec_t req_eff;
  sel_t     win;
  logic     any_gnt;
  logic     pick_en;

  // Reset level gates the grant so nothing is issued while rst_n is low.
  assign pick_en = rst_n & ~stall;

`ifdef WB_ARB_LOCK_EN
  logic locked_q;
  logic locked_d;
  sel_t owner_q;
  sel_t owner_d;

  // While locked only the owner's request is visible to the picker.
  always_comb begin
    req_eff = req;
    if (locked_q) begin
      req_eff = req & (req_vec_t'(1) << owner_q);
    end
  end
`else
  assign req_eff = req;
`endif

  rr_pick u_pick (
    .req     (req_eff),
    .ptr     (ptr_q),
    .en      (pick_en),
    .gnt     (gnt),
    .idx     (win),
    .any_gnt (any_gnt)
  );

  // Next-state: pointer, select registers and lock state.
  always_comb begin
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    if (any_gnt) begin
      ptr_d   = win + sel_t'(1);
      sel_d   = win;
      valid_d = 1'b1;
    end
`ifdef WB_ARB_LOCK_EN
    locked_d = locked_q;
    owner_d  = owner_q;
    if (locked_q) begin
      if (!lock[owner_q] || !req[owner_q]) begin
        locked_d = 1'b0;
      end
    end else if (any_gnt && lock[win]) begin
      locked_d = 1'b1;
      owner_d  = win;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
`ifdef WB_ARB_LOCK_EN
      locked_q    <= 1'b0;
      owner_q     <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      sel_valid_q <= valid_d;
`ifdef WB_ARB_LOCK_EN
      locked_q    <= locked_d;
      owner_q     <= owner_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_sel_arbiter.sv
// Directed self-checking bench for wb_sel_arbiter (lock scenarios when WB_ARB_LOCK_EN is defined).
module tb_wb_sel_arbiter;
  import wb_arb_pkg::*;

  logic     clk;
  logic     rst_n;
  req_vec_t req;
  logic     stall;
`ifdef WB_ARB_LOCK_EN
  req_vec_t lock;
`endif
  req_vec_t gnt;
  sel_t     sel_q;
  logic     sel_valid_q;

  int n_cmp;
  int n_err;

  wb_sel_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .stall       (stall),
`ifdef WB_ARB_LOCK_EN
    .lock        (lock),
`endif
    .gnt         (gnt),
    .sel_q       (sel_q),
    .sel_valid_q (sel_valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled mid-low-phase.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    next_cycle();
    n_cmp++; if (gnt !== 8'h00) begin n_err++; $display("FAIL reset_gnt got=%h exp=00", gnt); end
    n_cmp++; if (sel_q !== 3'd0) begin n_err++; $display("FAIL reset_sel got=%0d exp=0", sel_q); end
    n_cmp++; if (sel_valid_q !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", sel_valid_q); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (gnt !== 8'h01) begin n_err++; $display("FAIL reset_first_gnt got=%h exp=01", gnt); end
  endtask

  // Starts from ptr=0 with req=FF already applied and the first grant pending.
  task automatic test_rotation();
    req_vec_t exp_g;
    for (int i = 0; i < 16; i++) begin
      exp_g = req_vec_t'(1) << (i % 8);
      n_cmp++; if (gnt !== exp_g) begin n_err++; $display("FAIL rot_gnt[%0d] got=%h exp=%h", i, gnt, exp_g); end
      if (i > 0) begin
        n_cmp++; if (sel_q !== sel_t'((i - 1) % 8) || sel_valid_q !== 1'b1) begin
          n_err++; $display("FAIL rot_sel[%0d] got=%0d/%b exp=%0d/1", i, sel_q, sel_valid_q, (i - 1) % 8);
        end
      end
      next_cycle();
    end
    req = 8'h00;
    #1;
    n_cmp++; if (sel_q !== 3'd7 || sel_valid_q !== 1'b1) begin n_err++; $display("FAIL rot_last got=%0d/%b exp=7/1", sel_q, sel_valid_q); end
    next_cycle();
  endtask

  // ptr=0 on entry; set ptr=6 via a grant to index 5, then check the wrap.
  task automatic test_wrap();
    req = 8'h20;
    #1;
    n_cmp++; if (gnt !== 8'h20) begin n_err++; $display("FAIL wrap_setup got=%h exp=20", gnt); end
    next_cycle();
    req = 8'h41;
    #1;
    n_cmp++; if (gnt !== 8'h40) begin n_err++; $display("FAIL wrap_gnt6 got=%h exp=40", gnt); end
    next_cycle();
    req = 8'h01;
    #1;
    n_cmp++; if (gnt !== 8'h01) begin n_err++; $display("FAIL wrap_gnt0 got=%h exp=01", gnt); end
    n_cmp++; if (sel_q !== 3'd6) begin n_err++; $display("FAIL wrap_sel6 got=%0d exp=6", sel_q); end
    next_cycle();
    req = 8'h03;
    #1;
    n_cmp++; if (gnt !== 8'h02) begin n_err++; $display("FAIL wrap_ptr1 got=%h exp=02", gnt); end
    n_cmp++; if (sel_q !== 3'd0) begin n_err++; $display("FAIL wrap_sel0 got=%0d exp=0", sel_q); end
    next_cycle();
    req = 8'h00;
    #1;
    next_cycle();
    n_cmp++; if (sel_valid_q !== 1'b0 || sel_q !== 3'd1) begin n_err++; $display("FAIL idle_hold got=%0d/%b exp=1/0", sel_q, sel_valid_q); end
  endtask

  // ptr=2 on entry.
  task automatic test_stall();
    req   = 8'h0C;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (gnt !== 8'h00) begin n_err++; $display("FAIL stall_gnt[%0d] got=%h exp=00", i, gnt); end
      n_cmp++; if (sel_valid_q !== 1'b0 || sel_q !== 3'd1) begin n_err++; $display("FAIL stall_sel[%0d] got=%0d/%b exp=1/0", i, sel_q, sel_valid_q); end
      next_cycle();
    end
    stall = 1'b0;
    #1;
    n_cmp++; if (gnt !== 8'h04) begin n_err++; $display("FAIL stall_rel0 got=%h exp=04", gnt); end
    next_cycle();
    n_cmp++; if (gnt !== 8'h08) begin n_err++; $display("FAIL stall_rel1 got=%h exp=08", gnt); end
    n_cmp++; if (sel_q !== 3'd2 || sel_valid_q !== 1'b1) begin n_err++; $display("FAIL stall_sel2 got=%0d/%b exp=2/1", sel_q, sel_valid_q); end
    next_cycle();
    req = 8'h00;
    #1;
    next_cycle();
  endtask

  // ptr=4 on entry.
  task automatic test_back_to_back();
    req = 8'h02;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (gnt !== 8'h02) begin n_err++; $display("FAIL b2b_gnt[%0d] got=%h exp=02", i, gnt); end
      next_cycle();
    end
    n_cmp++; if (sel_q !== 3'd1 || sel_valid_q !== 1'b1) begin n_err++; $display("FAIL b2b_sel got=%0d/%b exp=1/1", sel_q, sel_valid_q); end
    req = 8'h81;
    #1;
    n_cmp++; if (gnt !== 8'h80) begin n_err++; $display("FAIL simul_first got=%h exp=80", gnt); end
    next_cycle();
    n_cmp++; if (gnt !== 8'h01) begin n_err++; $display("FAIL simul_second got=%h exp=01", gnt); end
    next_cycle();
    req = 8'h00;
    #1;
    next_cycle();
  endtask

`ifdef WB_ARB_LOCK_EN
  // ptr=1 on entry.
  task automatic test_lock();
    req  = 8'h30;
    lock = 8'h10;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (gnt !== 8'h10) begin n_err++; $display("FAIL lock_gnt[%0d] got=%h exp=10", i, gnt); end
      next_cycle();
    end
    lock = 8'h00;
    #1;
    n_cmp++; if (gnt !== 8'h10) begin n_err++; $display("FAIL lock_release_cycle got=%h exp=10", gnt); end
    next_cycle();
    n_cmp++; if (gnt !== 8'h20) begin n_err++; $display("FAIL lock_after got=%h exp=20", gnt); end
    next_cycle();
    req = 8'h00;
    #1;
    next_cycle();
  endtask
`endif

  task automatic test_midreset();
    req = 8'h30;
`ifdef WB_ARB_LOCK_EN
    lock = 8'h10;
`endif
    next_cycle();
    next_cycle();
    n_cmp++; if (gnt !== 8'h10) begin n_err++; $display("FAIL midrst_pre got=%h exp=10", gnt); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (gnt !== 8'h00) begin n_err++; $display("FAIL midrst_gnt got=%h exp=00", gnt); end
    n_cmp++; if (sel_q !== 3'd0 || sel_valid_q !== 1'b0) begin n_err++; $display("FAIL midrst_sel got=%0d/%b exp=0/0", sel_q, sel_valid_q); end
    next_cycle();
    req = 8'hFF;
`ifdef WB_ARB_LOCK_EN
    lock = 8'h00;
`endif
    rst_n = 1'b1;
    #1;
    n_cmp++; if (gnt !== 8'h01) begin n_err++; $display("FAIL midrst_first got=%h exp=01", gnt); end
    next_cycle();
    n_cmp++; if (gnt !== 8'h02) begin n_err++; $display("FAIL midrst_second got=%h exp=02", gnt); end
    req = 8'h00;
    next_cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 8'h00;
    stall = 1'b0;
`ifdef WB_ARB_LOCK_EN
    lock  = 8'h00;
`endif
    test_reset();
    test_rotation();
    test_wrap();
    test_stall();
    test_back_to_back();
`ifdef WB_ARB_LOCK_EN
    test_lock();
`endif
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
